// File: rtl/cascade_divider_if.sv
// Control and status bundle for cascade_divider: enable/clear in, counts,
// strobes, divided clocks and one-shot flag out.
interface cascade_divider_if #(
  parameter int W_A = 6,
  parameter int W_B = 4
) ();
  logic           en;
  logic           clr;
  logic [W_A-1:0] count_a;
  logic [W_B-1:0] count_b;
  logic           tick_a;
  logic           tick_b;
  logic           clk_div_a;
  logic           clk_div_b;
  logic           done;

  modport master (
    output en, clr,
    input  count_a, count_b, tick_a, tick_b, clk_div_a, clk_div_b, done
  );

  modport slave (
    input  en, clr,
    output count_a, count_b, tick_a, tick_b, clk_div_a, clk_div_b, done
  );
endinterface

// File: rtl/cascade_divider.sv
// Two-stage cascaded modulo counter / clock divider on a single clock;
// stage B advances on stage-A terminal-count enables, optional one-shot stop.

module cascade_stage #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         div
);
  logic [W-1:0] nxt;

  always_comb begin
    last = (cnt == W'(MOD - 1));
    nxt  = last ? '0 : cnt + W'(1);
  end

  // div is loaded from the next count so it changes on the same edge as cnt
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      div <= 1'b0;
    end else if (adv) begin
      cnt <= nxt;
      div <= (nxt >= W'(MOD / 2));
    end
  end
endmodule

module cascade_divider #(
  parameter int MOD_A    = 50,
  parameter int MOD_B    = 10,
  parameter int W_A      = $clog2(MOD_A),
  parameter int W_B      = $clog2(MOD_B),
  parameter int ONE_SHOT = 0
) (
  input logic              clk,
  input logic              rst,
  cascade_divider_if.slave bus
);
  logic           run;
  logic           tick_a;
  logic           tick_b;
  logic           last_a;
  logic           last_b;
  logic           div_a;
  logic           div_b;
  logic           done;
  logic [W_A-1:0] cnt_a;
  logic [W_B-1:0] cnt_b;

  if (MOD_A < 2 || MOD_B < 2 || MOD_A > (1 << W_A) || MOD_B > (1 << W_B)) begin : g_bad_params
    $error("cascade_divider: moduli must be >= 2 and fit in W_A/W_B");
  end

  assign run    = bus.en & ~done & ~rst & ~bus.clr;
  assign tick_a = run & last_a;
  assign tick_b = tick_a & last_b;

  cascade_stage #(.MOD(MOD_A), .W(W_A)) u_stage_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .adv  (run),
    .cnt  (cnt_a),
    .last (last_a),
    .div  (div_a)
  );

  cascade_stage #(.MOD(MOD_B), .W(W_B)) u_stage_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .adv  (tick_a),
    .cnt  (cnt_b),
    .last (last_b),
    .div  (div_b)
  );

  if (ONE_SHOT != 0) begin : g_fsm
    typedef enum logic {S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk) begin
      if (rst || bus.clr) state <= S_RUN;
      else                state <= state_nxt;
    end

    always_comb begin
      state_nxt = state;
      case (state)
        S_RUN:   if (tick_b) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_RUN;
      endcase
    end

    always_comb begin
      done = (state == S_DONE);
    end
  end else begin : g_free
    assign done = 1'b0;
  end

  assign bus.count_a   = cnt_a;
  assign bus.count_b   = cnt_b;
  assign bus.tick_a    = tick_a;
  assign bus.tick_b    = tick_b;
  assign bus.clk_div_a = div_a;
  assign bus.clk_div_b = div_b;
  assign bus.done      = done;
endmodule

// File: tb/tb_cascade_divider.sv
// Bench for cascade_divider: three configurations checked each cycle against a
// model that tracks the chain as one flat count n in 0..MOD_A*MOD_B-1.
module tb_cascade_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cascade_divider_if #(.W_A(6), .W_B(4)) if_d ();
  cascade_divider_if #(.W_A(2), .W_B(2)) if_o ();
  cascade_divider_if #(.W_A(3), .W_B(1)) if_p ();

  cascade_divider #(.MOD_A(50), .MOD_B(10)) u_d (.clk(clk), .rst(rst), .bus(if_d));
  cascade_divider #(.MOD_A(4), .MOD_B(3), .ONE_SHOT(1)) u_o (.clk(clk), .rst(rst), .bus(if_o));
  cascade_divider #(.MOD_A(5), .MOD_B(2)) u_p (.clk(clk), .rst(rst), .bus(if_p));

  int n_d = 0, n_o = 0, n_p = 0;
  bit d_d = 0, d_o = 0, d_p = 0;

  function automatic int nxt_n(int n, int ma, int mb, bit d, bit en, bit clr, bit r);
    if (r || clr) return 0;
    if (!en || d) return n;
    return (n == ma * mb - 1) ? 0 : n + 1;
  endfunction

  function automatic bit nxt_d(int n, int ma, int mb, bit os, bit d, bit en, bit clr, bit r);
    if (r || clr) return 1'b0;
    if (os && en && !d && n == ma * mb - 1) return 1'b1;
    return d;
  endfunction

  // {count_a[7:0], count_b[7:0], tick_a, tick_b, clk_div_a, clk_div_b, done}
  function automatic logic [20:0] exp_v(int n, int ma, int mb, bit d, bit en, bit clr, bit r);
    int a, b;
    bit run, ta, tbk, ca, cb;
    a   = n % ma;
    b   = n / ma;
    run = en && !d && !r && !clr;
    ta  = run && (a == ma - 1);
    tbk = ta && (b == mb - 1);
    ca  = (a >= ma / 2);
    cb  = (b >= mb / 2);
    return {a[7:0], b[7:0], ta, tbk, ca, cb, d};
  endfunction

  always @(posedge clk) begin
    n_d <= nxt_n(n_d, 50, 10, d_d, if_d.en, if_d.clr, rst);
    d_d <= nxt_d(n_d, 50, 10, 1'b0, d_d, if_d.en, if_d.clr, rst);
    n_o <= nxt_n(n_o, 4, 3, d_o, if_o.en, if_o.clr, rst);
    d_o <= nxt_d(n_o, 4, 3, 1'b1, d_o, if_o.en, if_o.clr, rst);
    n_p <= nxt_n(n_p, 5, 2, d_p, if_p.en, if_p.clr, rst);
    d_p <= nxt_d(n_p, 5, 2, 1'b0, d_p, if_p.en, if_p.clr, rst);
  end

  logic [20:0] e_d, e_o, e_p, g_d, g_o, g_p;
  assign e_d = exp_v(n_d, 50, 10, d_d, if_d.en, if_d.clr, rst);
  assign e_o = exp_v(n_o, 4, 3, d_o, if_o.en, if_o.clr, rst);
  assign e_p = exp_v(n_p, 5, 2, d_p, if_p.en, if_p.clr, rst);
  assign g_d = {8'(if_d.count_a), 8'(if_d.count_b), if_d.tick_a, if_d.tick_b,
                if_d.clk_div_a, if_d.clk_div_b, if_d.done};
  assign g_o = {8'(if_o.count_a), 8'(if_o.count_b), if_o.tick_a, if_o.tick_b,
                if_o.clk_div_a, if_o.clk_div_b, if_o.done};
  assign g_p = {8'(if_p.count_a), 8'(if_p.count_b), if_p.tick_a, if_p.tick_b,
                if_p.clk_div_a, if_p.clk_div_b, if_p.done};

  task automatic test_reset();
    rst = 1'b1;
    if_d.en = 0; if_d.clr = 0;
    if_o.en = 0; if_o.clr = 0;
    if_p.en = 0; if_p.clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (g_d !== 21'h0) begin bad++; $display("FAIL reset_d got=%h exp=0", g_d); end
    total++; if (g_o !== 21'h0) begin bad++; $display("FAIL reset_o got=%h exp=0", g_o); end
    total++; if (g_p !== 21'h0) begin bad++; $display("FAIL reset_p got=%h exp=0", g_p); end
    rst = 1'b0;
  endtask

  task automatic test_count();
    int ta_n = 0, tb_n = 0, first_ta = -1, first_tb = -1, hi_a = 0, hi_b = 0;
    if_d.en = 1;
    for (int c = 0; c < 1000; c++) begin
      #1;
      total++; if (g_d !== e_d) begin bad++; $display("FAIL count c=%0d got=%h exp=%h", c, g_d, e_d); end
      if (if_d.tick_a === 1'b1) begin if (first_ta < 0) first_ta = c; ta_n++; end
      if (if_d.tick_b === 1'b1) begin if (first_tb < 0) first_tb = c; tb_n++; end
      if (if_d.clk_div_a === 1'b1) hi_a++;
      if (if_d.clk_div_b === 1'b1) hi_b++;
      @(negedge clk);
    end
    total++; if (first_ta != 49) begin bad++; $display("FAIL first_tick_a got=%0d exp=49", first_ta); end
    total++; if (first_tb != 499) begin bad++; $display("FAIL first_tick_b got=%0d exp=499", first_tb); end
    total++; if (ta_n != 20) begin bad++; $display("FAIL tick_a_count got=%0d exp=20", ta_n); end
    total++; if (tb_n != 2) begin bad++; $display("FAIL tick_b_count got=%0d exp=2", tb_n); end
    total++; if (hi_a != 500) begin bad++; $display("FAIL div_a_high got=%0d exp=500", hi_a); end
    total++; if (hi_b != 500) begin bad++; $display("FAIL div_b_high got=%0d exp=500", hi_b); end
  endtask

  task automatic test_en_toggle();
    for (int r = 0; r < 3; r++) begin
      if_d.en = 1;
      for (int k = 0; k < 100 && (n_d % 50) != 47; k++) @(negedge clk);
      total++; if (if_d.count_a !== 6'd47) begin bad++; $display("FAIL en_reach got=%0d exp=47", if_d.count_a); end
      for (int c = 0; c < 30; c++) begin
        if_d.en = 1'($urandom_range(0, 1));
        #1;
        total++; if (g_d !== e_d) begin bad++; $display("FAIL en_toggle r=%0d c=%0d en=%0b got=%h exp=%h", r, c, if_d.en, g_d, e_d); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_clr();
    if_d.en = 1;
    for (int k = 0; k < 600 && n_d != 380; k++) @(negedge clk);
    total++; if ({if_d.count_b, if_d.count_a} !== {4'd7, 6'd30}) begin
      bad++; $display("FAIL clr_reach got=%0d/%0d exp=7/30", if_d.count_b, if_d.count_a); end
    if_d.clr = 1;
    #1;
    total++; if (g_d !== e_d) begin bad++; $display("FAIL clr_cycle got=%h exp=%h", g_d, e_d); end
    @(negedge clk);
    total++; if (g_d !== 21'h0) begin bad++; $display("FAIL clr_zero got=%h exp=0", g_d); end
    if_d.clr = 0;
    @(negedge clk);
    total++; if ({if_d.count_b, if_d.count_a} !== {4'd0, 6'd1}) begin
      bad++; $display("FAIL clr_resume got=%0d/%0d exp=0/1", if_d.count_b, if_d.count_a); end
  endtask

  task automatic test_one_shot();
    rst = 1; @(negedge clk); rst = 0;
    if_o.en = 1;
    for (int r = 0; r < 2; r++) begin
      int first_tb = -1, first_done = -1;
      for (int c = 0; c < 20; c++) begin
        #1;
        total++; if (g_o !== e_o) begin bad++; $display("FAIL one_shot r=%0d c=%0d got=%h exp=%h", r, c, g_o, e_o); end
        if (if_o.tick_b === 1'b1 && first_tb < 0) first_tb = c;
        if (if_o.done === 1'b1 && first_done < 0) first_done = c;
        @(negedge clk);
      end
      total++; if (first_tb != 11) begin bad++; $display("FAIL os_tick_b r=%0d got=%0d exp=11", r, first_tb); end
      total++; if (first_done != 12) begin bad++; $display("FAIL os_done r=%0d got=%0d exp=12", r, first_done); end
      total++; if (g_o !== 21'h1) begin bad++; $display("FAIL os_hold r=%0d got=%h exp=1", r, g_o); end
      if_o.clr = 1; @(negedge clk); if_o.clr = 0;
    end
  endtask

  task automatic test_odd();
    int hi_a = 0, hi_b = 0;
    rst = 1; @(negedge clk); rst = 0;
    if_p.en = 1;
    for (int c = 0; c < 30; c++) begin
      #1;
      total++; if (g_p !== e_p) begin bad++; $display("FAIL odd c=%0d got=%h exp=%h", c, g_p, e_p); end
      if (c < 10 && if_p.clk_div_a === 1'b1) hi_a++;
      if (c < 10 && if_p.clk_div_b === 1'b1) hi_b++;
      @(negedge clk);
    end
    total++; if (hi_a != 6) begin bad++; $display("FAIL odd_div_a got=%0d exp=6", hi_a); end
    total++; if (hi_b != 5) begin bad++; $display("FAIL odd_div_b got=%0d exp=5", hi_b); end
  endtask

  task automatic test_rst_clr();
    if_d.en = 1;
    for (int k = 0; k < 600 && n_d != 499; k++) @(negedge clk);
    total++; if ({if_d.count_b, if_d.count_a} !== {4'd9, 6'd49}) begin
      bad++; $display("FAIL rc_reach got=%0d/%0d exp=9/49", if_d.count_b, if_d.count_a); end
    rst = 1; if_d.clr = 1;
    #1;
    total++; if (if_d.tick_b !== 1'b0 || if_d.tick_a !== 1'b0) begin
      bad++; $display("FAIL rc_no_tick got=%b%b exp=00", if_d.tick_a, if_d.tick_b); end
    @(negedge clk);
    total++; if (g_d !== 21'h0) begin bad++; $display("FAIL rc_zero got=%h exp=0", g_d); end
    rst = 0; if_d.clr = 0;
    // clr racing the final tick of a one-shot run must leave done low
    if_o.clr = 1; @(negedge clk); if_o.clr = 0;
    if_o.en = 1;
    for (int k = 0; k < 40 && n_o != 11; k++) @(negedge clk);
    total++; if ({if_o.count_b, if_o.count_a} !== {2'd2, 2'd3}) begin
      bad++; $display("FAIL os_reach got=%0d/%0d exp=2/3", if_o.count_b, if_o.count_a); end
    if_o.clr = 1;
    #1;
    total++; if (if_o.tick_b !== 1'b0) begin bad++; $display("FAIL os_clr_tick got=%b exp=0", if_o.tick_b); end
    @(negedge clk);
    total++; if (g_o !== 21'h0) begin bad++; $display("FAIL os_clr_done got=%h exp=0", g_o); end
    if_o.clr = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if_d.en = ($urandom_range(0, 3) != 0); if_d.clr = ($urandom_range(0, 31) == 0);
      if_o.en = ($urandom_range(0, 3) != 0); if_o.clr = ($urandom_range(0, 31) == 0);
      if_p.en = ($urandom_range(0, 3) != 0); if_p.clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      total++; if (g_d !== e_d) begin bad++; $display("FAIL rand_d c=%0d got=%h exp=%h", c, g_d, e_d); end
      total++; if (g_o !== e_o) begin bad++; $display("FAIL rand_o c=%0d got=%h exp=%h", c, g_o, e_o); end
      total++; if (g_p !== e_p) begin bad++; $display("FAIL rand_p c=%0d got=%h exp=%h", c, g_p, e_p); end
      @(negedge clk);
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_en_toggle();
    test_clr();
    test_one_shot();
    test_odd();
    test_rst_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cascade_divider.md
Name: cascade_divider

Overview:
Parametrised two-stage cascaded modulo counter and clock divider, and the successor to the fixed mod-50/mod-10 divider pair. The whole chain runs on one clock. Stage B advances on stage-A terminal-count enables, not on a derived clock. The block provides count values, single-cycle tick strobes, registered near-50%-duty divided clocks, and an optional one-shot mode with a done flag. It feeds timebase and slow-blink logic in the top level.

Parameters:
MOD_A, 50, stage-A modulus; must be >= 2.
MOD_B, 10, stage-B modulus; must be >= 2.
W_A, $clog2(MOD_A), stage-A count width; default gives 6 for MOD_A = 50.
W_B, $clog2(MOD_B), stage-B count width; default gives 4 for MOD_B = 10.
ONE_SHOT, 0, 0 = free-running; 1 = stop after one full MOD_A*MOD_B sequence.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  count enable for stage A.
clr  input  1  synchronous clear of counters and the done flag.
count_a  output  W_A  stage-A count, 0..MOD_A-1.
count_b  output  W_B  stage-B count, 0..MOD_B-1.
tick_a  output  1  one-cycle strobe on stage-A wrap.
tick_b  output  1  one-cycle strobe on full-chain wrap.
clk_div_a  output  1  divided clock, period MOD_A cycles.
clk_div_b  output  1  divided clock, period MOD_A*MOD_B cycles.
done  output  1  one-shot complete; held at 0 when ONE_SHOT = 0.

Behaviour:
- Reset and priority: one clock; reset is synchronous and active-high (ports clk, rst). Priority is rst > clr > en.
- Values after rst or clr: count_a = 0, count_b = 0, clk_div_a = 0, clk_div_b = 0, done = 0. tick_a and tick_b are 0 whenever rst or clr is high.
- Run condition: run = en & ~done & ~rst & ~clr.
- Stage A: if run, count_a <= (count_a == MOD_A-1) ? 0 : count_a + 1. Otherwise count_a holds.
- tick_a (combinational) = run & (count_a == MOD_A-1). It is high in the cycle before count_a wraps to 0.
- Stage B: advances only when tick_a is high, wrapping at MOD_B-1. Otherwise count_b holds.
- tick_b (combinational) = tick_a & (count_b == MOD_B-1).
- clk_div_a is a flop loaded with (next count_a >= MOD_A/2), integer floor, so it stays aligned with count_a.
  - High time is MOD_A - floor(MOD_A/2) cycles; low time is floor(MOD_A/2) cycles.
  - MOD_A = 50: low for counts 0..24, high for counts 25..49.
  - MOD_A = 5: low for counts 0..1, high for counts 2..4.
- clk_div_b: same rule, applied to count_b.
- While en is low, all counts and divided clocks freeze; no glitches and no ticks.
- FSM (ONE_SHOT = 1 only), states RUN and DONE:
  - RUN -> DONE on tick_b. Counters wrap to 0 and divided clocks go to 0 on that edge; done = 1 from the next cycle.
  - DONE holds everything static and ignores en.
  - DONE -> RUN on clr or rst only.
  - When clr and tick_b coincide, clr wins: done stays 0.
- ONE_SHOT = 0: the FSM is absent and done is tied to 0.
- Mid-count clr or rst: all outputs return to their reset values on that edge. With en high, counting resumes from 0 on the following edge.
- Parameter legality: elaboration fails if MOD_A < 2, MOD_B < 2, or the widths are too narrow for the moduli.

Test Plan:
1. Defaults, rst high for 2 cycles, then en = 1 for 1000 cycles.
   - count_a cycles 0..49.
   - tick_a occurs every 50 cycles, first at cycle 49 after rst is released.
   - count_b increments once per 50 cycles; tick_b occurs at cycle 499 and every 500 cycles after.
   - clk_div_a is low for 25 cycles and high for 25; clk_div_b is low for 250 cycles and high for 250.
2. en toggled 1-0-1 for a random number of cycles around count_a = 49.
   - While en = 0, counts hold and no tick fires.
   - tick_a fires in the first en = 1 cycle with count_a = 49.
3. clr asserted at count_a = 30, count_b = 7.
   - Next cycle: count_a = 0, count_b = 0, both divided clocks 0, no tick.
   - Counting resumes at 1 on the following edge.
4. ONE_SHOT = 1, MOD_A = 4, MOD_B = 3, en held at 1.
   - tick_b occurs at cycle 11 and done = 1 at cycle 12.
   - Counts stay at 0 while en remains high.
   - clr releases done, and the sequence repeats.
5. MOD_A = 5 (odd), MOD_B = 2.
   - clk_div_a is low for 2 cycles and high for 3 per 5-cycle period.
   - clk_div_b has a 10-cycle period, low for 5 and high for 5.
6. rst and clr asserted together at count_b = MOD_B-1 with tick_a pending.
   - rst wins: outputs return to reset values.
   - No tick_b is emitted and done = 0.
